// File: rtl/leaf_double_mux.sv
// Leaf-side 2:1 packet mux/demux between one BFT leaf port and a double-page slot.
// Egress merges two per-page FIFOs round-robin; ingress steers by one header bit.
module leaf_double_mux #(
  parameter int unsigned PKT_W   = 49,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned SEL_BIT = 43,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_400,
  input  logic             reset_400_n,
  input  logic [PKT_W-1:0] din_leaf_bft2interface,
  output logic [PKT_W-1:0] dout_leaf_interface2bft,
  input  logic             resend_in,
  input  logic [PKT_W-1:0] dout_leaf_interface2bft_0,
  input  logic [PKT_W-1:0] dout_leaf_interface2bft_1,
  output logic [PKT_W-1:0] din_leaf_bft2interface_0,
  output logic [PKT_W-1:0] din_leaf_bft2interface_1,
  output logic             resend_0,
  output logic             resend_1,
  output logic [CNT_W-1:0] drop_cnt_0,
  output logic [CNT_W-1:0] drop_cnt_1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW+1)'(DEPTH - 2);

  typedef enum logic {RR_P0, RR_P1} rr_t;

  rr_t rr_q, rr_d;
  logic [1:0][PKT_W-1:0] page_pkt;
  logic [1:0][PKT_W-1:0] head;
  logic [1:0][CNT_W-1:0] drop;
  logic [1:0]            empty, full, pop, af;

  assign page_pkt = {dout_leaf_interface2bft_1, dout_leaf_interface2bft_0};

  // Ingress: registered steer, invalid packets become all-zero on both pages
  always_ff @(posedge clk_400 or negedge reset_400_n) begin
    if (!reset_400_n) begin
      din_leaf_bft2interface_0 <= '0;
      din_leaf_bft2interface_1 <= '0;
    end else begin
      din_leaf_bft2interface_0 <= (din_leaf_bft2interface[PKT_W-1] && !din_leaf_bft2interface[SEL_BIT])
                                  ? din_leaf_bft2interface : '0;
      din_leaf_bft2interface_1 <= (din_leaf_bft2interface[PKT_W-1] && din_leaf_bft2interface[SEL_BIT])
                                  ? din_leaf_bft2interface : '0;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, cnt;
    logic [CNT_W-1:0] drop_q;
    logic             af_q, push, accept;

    assign cnt      = wr_ptr - rd_ptr;
    assign push     = page_pkt[k][PKT_W-1];
    assign empty[k] = (wr_ptr == rd_ptr);
    assign full[k]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign accept   = push && (!full[k] || pop[k]);
    assign head[k]  = mem[rd_ptr[AW-1:0]];
    assign drop[k]  = drop_q;
    assign af[k]    = af_q;

    always_ff @(posedge clk_400) begin
      if (accept) mem[wr_ptr[AW-1:0]] <= page_pkt[k];
    end

    always_ff @(posedge clk_400 or negedge reset_400_n) begin
      if (!reset_400_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        drop_q <= '0;
        af_q   <= 1'b0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        if (pop[k]) rd_ptr <= rd_ptr + 1'b1;
        if (push && !accept && (drop_q != '1)) drop_q <= drop_q + 1'b1;
        af_q <= (cnt >= AF_LVL);
      end
    end
  end

  assign resend_0   = af[0];
  assign resend_1   = af[1];
  assign drop_cnt_0 = drop[0];
  assign drop_cnt_1 = drop[1];

  // Pointer only moves when both pages contend
  always_comb begin
    pop  = '0;
    rr_d = rr_q;
    if (!resend_in) begin
      if (!empty[0] && !empty[1]) begin
        if (rr_q == RR_P0) begin
          pop[0] = 1'b1;
          rr_d   = RR_P1;
        end else begin
          pop[1] = 1'b1;
          rr_d   = RR_P0;
        end
      end else if (!empty[0]) begin
        pop[0] = 1'b1;
      end else if (!empty[1]) begin
        pop[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_400 or negedge reset_400_n) begin
    if (!reset_400_n) begin
      rr_q                    <= RR_P0;
      dout_leaf_interface2bft <= '0;
    end else begin
      rr_q <= rr_d;
      if (!resend_in) begin
        if (pop[0])      dout_leaf_interface2bft <= head[0];
        else if (pop[1]) dout_leaf_interface2bft <= head[1];
        else             dout_leaf_interface2bft <= '0;
      end
    end
  end

endmodule
